// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared RGB332 types, expansion helper and default transparent key
package vga_pkg;

  typedef logic [7:0] rgb332_t;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } rgb888_t;

  localparam rgb332_t DEFAULT_TRANSPARENT = 8'hFF;

  // Replicating the channel LSB keeps full-scale inputs at full-scale outputs.
  function automatic rgb888_t expand_rgb332(input rgb332_t c);
    rgb888_t o;
    o.red   = {c[7:5], {5{c[5]}}};
    o.green = {c[4:2], {5{c[2]}}};
    o.blue  = {c[1:0], {6{c[0]}}};
    return o;
  endfunction

endpackage

// File: rtl/priority_select.sv
// rtl/priority_select.sv - combinational lowest-rank winner search, ties go to lower index
module priority_select #(
  parameter int NUM_LAYERS = 8,
  parameter int IDX_W      = $clog2(NUM_LAYERS)
) (
  input  logic [NUM_LAYERS-1:0]       req,
  input  logic [NUM_LAYERS*IDX_W-1:0] rank,
  output logic                        found,
  output logic [IDX_W-1:0]            winner
);

  logic [IDX_W-1:0] best_rank;

  // Strict less-than while scanning upward leaves ties with the lower index.
  always_comb begin
    found     = 1'b0;
    winner    = '0;
    best_rank = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (req[i] && (!found || (rank[i*IDX_W +: IDX_W] < best_rank))) begin
        found     = 1'b1;
        winner    = IDX_W'(i);
        best_rank = rank[i*IDX_W +: IDX_W];
      end
    end
  end

endmodule

// File: rtl/layer_compositor.sv
// rtl/layer_compositor.sv - ranked layer compositor with frame-latched config and collision flags
module layer_compositor
  import vga_pkg::*;
#(
  parameter int                 NUM_LAYERS  = 8,
  parameter int                 COLOR_W     = 8,
  parameter logic [COLOR_W-1:0] TRANSPARENT = DEFAULT_TRANSPARENT,
  localparam int                IDX_W       = $clog2(NUM_LAYERS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          startOfFrame,
  input  logic                          pixelValid,
  input  logic [NUM_LAYERS-1:0]         drawReq,
  input  logic [NUM_LAYERS*COLOR_W-1:0] layerRGB,
  input  logic [COLOR_W-1:0]            backGroundRGB,
  input  logic                          cfgWe,
  input  logic [IDX_W-1:0]              cfgLayer,
  input  logic [IDX_W-1:0]              cfgRank,
  input  logic                          cfgEnable,
  output logic [7:0]                    redOut,
  output logic [7:0]                    greenOut,
  output logic [7:0]                    blueOut,
  output logic                          pixelValidOut,
  output logic [NUM_LAYERS-1:0]         collision,
  output logic                          collisionValid
);

  logic [IDX_W-1:0]             shad_rank     [NUM_LAYERS];
  logic [IDX_W-1:0]             shad_rank_nxt [NUM_LAYERS];
  logic [IDX_W-1:0]             act_rank      [NUM_LAYERS];
  logic [NUM_LAYERS-1:0]        shad_en, shad_en_nxt, act_en, cur_en;
  logic [NUM_LAYERS*IDX_W-1:0]  act_rank_flat;

  logic [NUM_LAYERS-1:0]        opaque, eff, coll_bits, acc;
  logic                         s1_valid;
  logic [NUM_LAYERS-1:0]        s1_req;
  logic [NUM_LAYERS*COLOR_W-1:0] s1_rgb;
  logic [COLOR_W-1:0]           s1_bg;
  logic                         found;
  logic [IDX_W-1:0]             winner;
  logic [COLOR_W-1:0]           sel_color, color_q;
  rgb888_t                      rgb_exp;

  // Indices outside 0..NUM_LAYERS-1 never match, so such writes fall away.
  always_comb begin
    for (int i = 0; i < NUM_LAYERS; i++) begin
      shad_rank_nxt[i] = shad_rank[i];
      shad_en_nxt[i]   = shad_en[i];
      if (cfgWe && (cfgLayer == IDX_W'(i))) begin
        shad_rank_nxt[i] = cfgRank;
        shad_en_nxt[i]   = cfgEnable;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        shad_rank[i] <= IDX_W'(i);
        act_rank[i]  <= IDX_W'(i);
      end
      shad_en <= '1;
      act_en  <= '1;
    end else begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        shad_rank[i] <= shad_rank_nxt[i];
        if (startOfFrame) act_rank[i] <= shad_rank_nxt[i];
      end
      shad_en <= shad_en_nxt;
      if (startOfFrame) act_en <= shad_en_nxt;
    end
  end

  // The frame's first pixel is qualified with the config being latched on that same cycle;
  // ranks are read one stage later, by which time act_rank already holds the new frame.
  always_comb begin
    act_rank_flat = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      opaque[i] = (layerRGB[i*COLOR_W +: COLOR_W] != TRANSPARENT);
      cur_en[i] = startOfFrame ? shad_en_nxt[i] : act_en[i];
      act_rank_flat[i*IDX_W +: IDX_W] = act_rank[i];
    end
  end

  assign eff       = drawReq & cur_en & opaque;
  assign coll_bits = (pixelValid && (|(eff & (eff - NUM_LAYERS'(1))))) ? eff : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_req   <= '0;
      s1_rgb   <= '0;
      s1_bg    <= '0;
    end else begin
      s1_valid <= pixelValid;
      s1_req   <= pixelValid ? eff : '0;
      s1_rgb   <= layerRGB;
      s1_bg    <= backGroundRGB;
    end
  end

  priority_select #(
    .NUM_LAYERS (NUM_LAYERS),
    .IDX_W      (IDX_W)
  ) u_priority_select (
    .req    (s1_req),
    .rank   (act_rank_flat),
    .found  (found),
    .winner (winner)
  );

  always_comb begin
    sel_color = '0;
    if (s1_valid) sel_color = found ? s1_rgb[int'(winner)*COLOR_W +: COLOR_W] : s1_bg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      color_q       <= '0;
      pixelValidOut <= 1'b0;
    end else begin
      color_q       <= sel_color;
      pixelValidOut <= s1_valid;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc            <= '0;
      collision      <= '0;
      collisionValid <= 1'b0;
    end else begin
      collisionValid <= startOfFrame;
      if (startOfFrame) begin
        collision <= acc;
        acc       <= coll_bits;
      end else begin
        acc <= acc | coll_bits;
      end
    end
  end

  assign rgb_exp  = expand_rgb332(rgb332_t'(color_q));
  assign redOut   = rgb_exp.red;
  assign greenOut = rgb_exp.green;
  assign blueOut  = rgb_exp.blue;

endmodule

// File: tb/tb_layer_compositor.sv
// tb/tb_layer_compositor.sv - scoreboard bench for layer_compositor
module tb_layer_compositor;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         startOfFrame, pixelValid;
  logic [N-1:0] drawReq;
  logic [N*8-1:0] layerRGB;
  logic [7:0]   backGroundRGB;
  logic         cfgWe;
  logic [2:0]   cfgLayer, cfgRank;
  logic         cfgEnable;
  logic [7:0]   redOut, greenOut, blueOut;
  logic         pixelValidOut;
  logic [N-1:0] collision;
  logic         collisionValid;

  layer_compositor dut (
    .clk            (clk),
    .reset          (reset),
    .startOfFrame   (startOfFrame),
    .pixelValid     (pixelValid),
    .drawReq        (drawReq),
    .layerRGB       (layerRGB),
    .backGroundRGB  (backGroundRGB),
    .cfgWe          (cfgWe),
    .cfgLayer       (cfgLayer),
    .cfgRank        (cfgRank),
    .cfgEnable      (cfgEnable),
    .redOut         (redOut),
    .greenOut       (greenOut),
    .blueOut        (blueOut),
    .pixelValidOut  (pixelValidOut),
    .collision      (collision),
    .collisionValid (collisionValid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [7:0] color;
    int         cyc;
  } exp_t;

  exp_t       sbq[$];
  exp_t       e;
  int         m_sh_rank [N];
  int         m_act_rank[N];
  bit         m_sh_en   [N];
  bit         m_act_en  [N];
  logic [7:0] m_acc, m_coll;

  function automatic logic [23:0] expand(input logic [7:0] c);
    return {c[7:5], {5{c[5]}}, c[4:2], {5{c[2]}}, c[1:0], {6{c[0]}}};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_sh_rank[i] = i; m_act_rank[i] = i;
      m_sh_en[i] = 1'b1; m_act_en[i] = 1'b1;
    end
    m_acc = '0;
    m_coll = '0;
    sbq.delete();
  endtask

  task automatic set_color(input int layer, input logic [7:0] c);
    layerRGB[layer*8 +: 8] = c;
  endtask

  task automatic cfg_write(input int layer, input int rank, input bit en);
    cfgWe = 1'b1;
    cfgLayer = 3'(layer);
    cfgRank = 3'(rank);
    cfgEnable = en;
  endtask

  // Drives one cycle from the current globals, predicts its colour and collision effect.
  task automatic step(input bit sof, input bit valid);
    logic [7:0] eff, coll;
    int best;
    startOfFrame = sof;
    pixelValid = valid;
    if (cfgWe) begin
      m_sh_rank[cfgLayer] = int'(cfgRank);
      m_sh_en[cfgLayer] = cfgEnable;
    end
    if (sof) begin
      for (int i = 0; i < N; i++) begin
        m_act_rank[i] = m_sh_rank[i];
        m_act_en[i] = m_sh_en[i];
      end
    end
    eff = '0;
    for (int i = 0; i < N; i++)
      eff[i] = drawReq[i] && m_act_en[i] && (layerRGB[i*8 +: 8] != 8'hFF);
    best = -1;
    for (int i = 0; i < N; i++)
      if (eff[i] && (best < 0 || m_act_rank[i] < m_act_rank[best])) best = i;
    if (valid)
      sbq.push_back('{(best < 0) ? backGroundRGB : layerRGB[best*8 +: 8], cyc + 2});
    coll = (valid && $countones(eff) >= 2) ? eff : 8'h00;
    if (sof) begin
      m_coll = m_acc;
      m_acc = coll;
    end else begin
      m_acc = m_acc | coll;
    end
    @(posedge clk);
    #1;
    cfgWe = 1'b0;
    check_val(sof ? "coll_valid_sof" : "coll_valid_idle", 32'(collisionValid), 32'(sof));
    check_val("collision", 32'(collision), 32'(m_coll));
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (pixelValidOut) begin
        if (sbq.size() == 0) begin
          check_val("unexpected_valid", 32'(pixelValidOut), 32'(0));
        end else begin
          e = sbq.pop_front();
          check_val("rgb", 32'({redOut, greenOut, blueOut}), 32'(expand(e.color)));
          check_val("latency", 32'(cyc), 32'(e.cyc));
        end
      end else begin
        check_val("idle_rgb", 32'({redOut, greenOut, blueOut}), 32'(0));
      end
    end
  end

  initial begin
    reset = 1'b1;
    startOfFrame = 1'b0; pixelValid = 1'b0; drawReq = '0; layerRGB = '0;
    backGroundRGB = '0; cfgWe = 1'b0; cfgLayer = '0; cfgRank = '0; cfgEnable = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_rgb", 32'({redOut, greenOut, blueOut}), 32'(0));
    check_val("rst_pvo", 32'(pixelValidOut), 32'(0));
    check_val("rst_coll", 32'(collision), 32'(0));
    check_val("rst_coll_valid", 32'(collisionValid), 32'(0));
    reset = 1'b0;
    step(1'b1, 1'b0);

    // Default index-order priority: layer 2 beats layer 5.
    drawReq = 8'b0010_0100;
    set_color(2, 8'h1C);
    set_color(5, 8'hE0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    check_val("default_prio", 32'({redOut, greenOut, blueOut}), 32'h00FF00);

    // Mid-frame re-rank must wait for the next frame.
    cfg_write(5, 0, 1'b1);
    step(1'b0, 1'b1);
    cfg_write(2, 2, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    check_val("shadow_hold", 32'({redOut, greenOut, blueOut}), 32'h00FF00);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    check_val("frame_swap", 32'({redOut, greenOut, blueOut}), 32'hFF0000);

    // Write coinciding with start of frame lands in this frame: tie goes to layer 2.
    cfg_write(2, 0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    check_val("sof_write", 32'({redOut, greenOut, blueOut}), 32'(expand(8'h1C)));

    // Transparent layer 0 neither draws nor collides.
    drawReq = 8'b0000_1001;
    layerRGB = '0;
    set_color(0, 8'hFF);
    set_color(3, 8'h03);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    check_val("transp_coll", 32'(collision), 32'(0));

    // Single overlap of layers 1 and 4.
    drawReq = 8'b0001_0010;
    set_color(1, 8'h25);
    set_color(4, 8'h4A);
    step(1'b0, 1'b1);
    drawReq = '0;
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    check_val("overlap_coll", 32'(collision), 32'h12);
    check_val("overlap_valid", 32'(collisionValid), 32'(1));
    step(1'b0, 1'b0);

    // Overlap on the start-of-frame pixel seeds the next accumulator.
    drawReq = 8'b1100_0000;
    set_color(6, 8'h11);
    set_color(7, 8'h22);
    step(1'b1, 1'b1);
    drawReq = '0;
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    check_val("seed_coll", 32'(collision), 32'hC0);

    // All layers disabled: background passes, idle cycles give 0.
    for (int i = 0; i < N; i++) begin
      cfg_write(i, i, 1'b0);
      step(1'b0, 1'b0);
    end
    backGroundRGB = 8'h6D;
    drawReq = 8'hFF;
    for (int i = 0; i < N; i++) set_color(i, 8'(i + 1));
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    check_val("background", 32'({redOut, greenOut, blueOut}), 32'(expand(8'h6D)));
    step(1'b0, 1'b0);
    check_val("invalid_zero", 32'({redOut, greenOut, blueOut}), 32'(0));

    // Random traffic with occasional re-config and frame starts.
    for (int n = 0; n < 300; n++) begin
      drawReq = 8'($urandom);
      backGroundRGB = 8'($urandom);
      for (int i = 0; i < N; i++)
        set_color(i, ($urandom_range(0, 5) == 0) ? 8'hFF : 8'($urandom));
      if ($urandom_range(0, 7) == 0)
        cfg_write(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0));
      step($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
    end

    // Reset with pixels in flight.
    cfg_write(0, 7, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check_val("midrst_rgb", 32'({redOut, greenOut, blueOut}), 32'(0));
    check_val("midrst_pvo", 32'(pixelValidOut), 32'(0));
    check_val("midrst_coll", 32'(collision | N'(collisionValid)), 32'(0));
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    drawReq = 8'b0010_0100;
    layerRGB = '0;
    set_color(2, 8'h1C);
    set_color(5, 8'hE0);
    step(1'b0, 1'b0);
    check_val("postrst_idle", 32'(pixelValidOut), 32'(0));
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    check_val("postrst_prio", 32'({redOut, greenOut, blueOut}), 32'h00FF00);

    drawReq = '0;
    repeat (4) step(1'b0, 1'b0);
    check_val("sb_drained", 32'(sbq.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
